// File: rtl/multicycle_ctrl_pkg.sv
// Shared RV32I instruction classes, controller state encoding and select codes.
package multicycle_ctrl_pkg;

  localparam int unsigned INSTR_W = 6;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [INSTR_W-1:0] {
    INSTR_ILLEGAL = 6'd0,
    INSTR_LUI     = 6'd1,
    INSTR_AUIPC   = 6'd2,
    INSTR_JAL     = 6'd3,
    INSTR_JALR    = 6'd4,
    INSTR_BEQ     = 6'd5,
    INSTR_BNE     = 6'd6,
    INSTR_BLT     = 6'd7,
    INSTR_BGE     = 6'd8,
    INSTR_BLTU    = 6'd9,
    INSTR_BGEU    = 6'd10,
    INSTR_LB      = 6'd11,
    INSTR_LH      = 6'd12,
    INSTR_LW      = 6'd13,
    INSTR_LBU     = 6'd14,
    INSTR_LHU     = 6'd15,
    INSTR_SB      = 6'd16,
    INSTR_SH      = 6'd17,
    INSTR_SW      = 6'd18,
    INSTR_ADDI    = 6'd19,
    INSTR_SLTI    = 6'd20,
    INSTR_SLTIU   = 6'd21,
    INSTR_XORI    = 6'd22,
    INSTR_ORI     = 6'd23,
    INSTR_ANDI    = 6'd24,
    INSTR_SLLI    = 6'd25,
    INSTR_SRLI    = 6'd26,
    INSTR_SRAI    = 6'd27,
    INSTR_ADD     = 6'd28,
    INSTR_SUB     = 6'd29,
    INSTR_SLL     = 6'd30,
    INSTR_SLT     = 6'd31,
    INSTR_SLTU    = 6'd32,
    INSTR_XOR     = 6'd33,
    INSTR_SRL     = 6'd34,
    INSTR_SRA     = 6'd35,
    INSTR_OR      = 6'd36,
    INSTR_AND     = 6'd37
  } rv32i_instr_e;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXECUTE  = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_WB       = 3'd5,
    ST_TRAP     = 3'd7
  } ctrl_state_e;

  localparam logic [SEL_W-1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [SEL_W-1:0] PC_SEL_IMM = 2'd1;
  localparam logic [SEL_W-1:0] PC_SEL_ALU = 2'd2;

  localparam logic [SEL_W-1:0] WB_SEL_ALU = 2'd0;
  localparam logic [SEL_W-1:0] WB_SEL_MEM = 2'd1;
  localparam logic [SEL_W-1:0] WB_SEL_PC4 = 2'd2;

  function automatic logic is_load(input rv32i_instr_e instr);
    return (instr >= INSTR_LB) && (instr <= INSTR_LHU);
  endfunction

  function automatic logic is_store(input rv32i_instr_e instr);
    return (instr >= INSTR_SB) && (instr <= INSTR_SW);
  endfunction

  function automatic logic is_branch(input rv32i_instr_e instr);
    return (instr >= INSTR_BEQ) && (instr <= INSTR_BGEU);
  endfunction

  // OP and OP_IMM arithmetic, all of which write rd from the ALU
  function automatic logic is_alu_op(input rv32i_instr_e instr);
    return (instr >= INSTR_ADDI) && (instr <= INSTR_AND);
  endfunction

  // Encodings beyond the last defined class are treated as illegal
  function automatic logic is_legal(input rv32i_instr_e instr);
    return (instr != INSTR_ILLEGAL) && (instr <= INSTR_AND);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Saturating wait counter with synchronous clear; flags the last allowed wait cycle.
module multicycle_ctrl_wait_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != {CW{1'b1}}) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (MAX_WAIT == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      assign expired_o = (cnt_q == CW'(MAX_WAIT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: fetch/decode/execute/memory/writeback
// sequencing with illegal-instruction and bus-timeout traps.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  rv32i_instr_e       instr_i,
  input  logic               branch_taken_i,
  output logic               imem_req_o,
  input  logic               imem_rvalid_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  output logic               ir_we_o,
  output logic               pc_we_o,
  output logic [SEL_W-1:0]   pc_sel_o,
  output logic               rf_we_o,
  output logic [SEL_W-1:0]   wb_sel_o,
  output logic               retire_o,
  output logic               illegal_o,
  output logic               bus_err_o,
  output logic [STATE_W-1:0] state_o
);

  ctrl_state_e state_q, state_d;
  logic        illegal_q, bus_err_q;
  logic        set_illegal, set_bus_err;
  logic        expired;

  multicycle_ctrl_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_d != state_q),
    .expired_o (expired)
  );

  // Outputs are held at zero while reset is asserted so that a mid-transaction
  // reset drops every request and enable immediately.
  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = PC_SEL_PC4;
    rf_we_o     = 1'b0;
    wb_sel_o    = WB_SEL_ALU;
    retire_o    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_rvalid_i) begin
            ir_we_o = 1'b1;
            state_d = ST_DECODE;
          end else if (expired) begin
            set_bus_err = 1'b1;
            state_d     = ST_TRAP;
          end
        end
        ST_DECODE: begin
          if (!is_legal(instr_i)) begin
            set_illegal = 1'b1;
            state_d     = ST_TRAP;
          end else begin
            state_d = ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (is_load(instr_i) || is_store(instr_i)) begin
            state_d = ST_MEM_REQ;
          end else begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            state_d  = ST_FETCH;
            if (instr_i == INSTR_JAL) begin
              pc_sel_o = PC_SEL_IMM;
            end else if (instr_i == INSTR_JALR) begin
              pc_sel_o = PC_SEL_ALU;
            end else if (is_branch(instr_i) && branch_taken_i) begin
              pc_sel_o = PC_SEL_IMM;
            end
            rf_we_o = !is_branch(instr_i);
            if ((instr_i == INSTR_JAL) || (instr_i == INSTR_JALR)) begin
              wb_sel_o = WB_SEL_PC4;
            end
          end
        end
        ST_MEM_REQ: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = is_store(instr_i);
          if (dmem_gnt_i) begin
            if (is_store(instr_i)) begin
              pc_we_o  = 1'b1;
              retire_o = 1'b1;
              state_d  = ST_FETCH;
            end else begin
              state_d = ST_MEM_WAIT;
            end
          end else if (expired) begin
            set_bus_err = 1'b1;
            state_d     = ST_TRAP;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_rvalid_i) begin
            state_d = ST_WB;
          end else if (expired) begin
            set_bus_err = 1'b1;
            state_d     = ST_TRAP;
          end
        end
        ST_WB: begin
          rf_we_o  = 1'b1;
          wb_sel_o = WB_SEL_MEM;
          pc_we_o  = 1'b1;
          retire_o = 1'b1;
          state_d  = ST_FETCH;
        end
        ST_TRAP: begin
          state_d = ST_TRAP;
        end
        default: begin
          state_d = ST_TRAP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  rv32i_instr_e instr;
  logic         branch_taken, imem_rvalid, dmem_gnt, dmem_rvalid;
  logic         imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, illegal, bus_err;
  logic [1:0]   pc_sel, wb_sel;
  logic [2:0]   state;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl #(.MAX_WAIT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_i        (instr),
    .branch_taken_i (branch_taken),
    .imem_req_o     (imem_req),
    .imem_rvalid_i  (imem_rvalid),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .dmem_gnt_i     (dmem_gnt),
    .dmem_rvalid_i  (dmem_rvalid),
    .ir_we_o        (ir_we),
    .pc_we_o        (pc_we),
    .pc_sel_o       (pc_sel),
    .rf_we_o        (rf_we),
    .wb_sel_o       (wb_sel),
    .retire_o       (retire),
    .illegal_o      (illegal),
    .bus_err_o      (bus_err),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] all_outs();
    return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
            retire, illegal, bus_err, state};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    instr = INSTR_ILLEGAL;
    {branch_taken, imem_rvalid, dmem_gnt, dmem_rvalid} = '0;
    #1;
    check("rst_outs", 32'(all_outs()), 32'h0);
    tick();
    tick();
    check("rst_held_outs", 32'(all_outs()), 32'h0);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic fetch_decode(input rv32i_instr_e ins);
    imem_rvalid = 1'b1;
    #1;
    check("fetch_state", 32'(state), 32'd0);
    check("fetch_ir_we", 32'(ir_we), 32'd1);
    tick();
    imem_rvalid = 1'b0;
    instr = ins;
    #1;
    check("decode_state", 32'(state), 32'd1);
    check("decode_pc_we", 32'(pc_we), 32'd0);
    tick();
  endtask

  task automatic run_alu(input rv32i_instr_e ins, input logic taken,
                         input logic [1:0] e_pc_sel, input logic e_rf_we, input logic [1:0] e_wb_sel);
    fetch_decode(ins);
    branch_taken = taken;
    #1;
    check("ex_state", 32'(state), 32'd2);
    check("ex_pc_we", 32'(pc_we), 32'd1);
    check("ex_retire", 32'(retire), 32'd1);
    check("ex_pc_sel", 32'(pc_sel), 32'(e_pc_sel));
    check("ex_rf_we", 32'(rf_we), 32'(e_rf_we));
    check("ex_wb_sel", 32'(wb_sel), 32'(e_wb_sel));
    check("ex_dmem_req", 32'(dmem_req), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    check("post_ex_state", 32'(state), 32'd0);
    check("post_ex_retire", 32'(retire), 32'd0);
  endtask

  initial begin
    apply_reset();

    run_alu(INSTR_ADDI, 1'b0, 2'd0, 1'b1, 2'd0);
    run_alu(INSTR_BEQ,  1'b1, 2'd1, 1'b0, 2'd0);
    run_alu(INSTR_BNE,  1'b0, 2'd0, 1'b0, 2'd0);
    run_alu(INSTR_JAL,  1'b0, 2'd1, 1'b1, 2'd2);
    run_alu(INSTR_JALR, 1'b1, 2'd2, 1'b1, 2'd2);
    run_alu(INSTR_LUI,  1'b1, 2'd0, 1'b1, 2'd0);
    run_alu(INSTR_SUB,  1'b0, 2'd0, 1'b1, 2'd0);

    // LW: gnt after two wait cycles, rvalid in first MEM_WAIT cycle
    fetch_decode(INSTR_LW);
    #1;
    check("lw_ex_state", 32'(state), 32'd2);
    check("lw_ex_retire", 32'(retire), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      dmem_gnt    = (i == 2);
      imem_rvalid = 1'b1;
      #1;
      check("lw_req_state", 32'(state), 32'd3);
      check("lw_req", 32'({dmem_req, dmem_we}), 32'b10);
      tick();
    end
    {dmem_gnt, imem_rvalid} = '0;
    dmem_rvalid = 1'b1;
    #1;
    check("lw_wait_state", 32'(state), 32'd4);
    check("lw_wait_req", 32'(dmem_req), 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    check("lw_wb_state", 32'(state), 32'd5);
    check("lw_wb_ctl", 32'({rf_we, wb_sel, pc_we, pc_sel, retire}), 32'b1_01_1_00_1);
    tick();
    check("lw_done_state", 32'(state), 32'd0);

    // LH: rvalid coinciding with gnt must not be taken
    fetch_decode(INSTR_LH);
    tick();
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    #1;
    check("lh_req_state", 32'(state), 32'd3);
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    #1;
    tick();
    check("lh_still_wait", 32'(state), 32'd4);
    dmem_rvalid = 1'b1;
    #1;
    tick();
    dmem_rvalid = 1'b0;
    #1;
    check("lh_wb_state", 32'(state), 32'd5);
    tick();

    // SW with immediate grant retires in the MEM_REQ cycle
    fetch_decode(INSTR_SW);
    tick();
    dmem_gnt = 1'b1;
    #1;
    check("sw_state", 32'(state), 32'd3);
    check("sw_ctl", 32'({dmem_req, dmem_we, pc_we, pc_sel, retire, rf_we}), 32'b1_1_1_00_1_0);
    tick();
    dmem_gnt = 1'b0;
    #1;
    check("sw_done", 32'({state, dmem_req, retire}), 32'b000_0_0);

    // Illegal instruction traps and stays trapped
    fetch_decode(INSTR_ILLEGAL);
    imem_rvalid = 1'b1;
    dmem_gnt    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("trap_state", 32'(state), 32'd7);
      check("trap_outs", 32'({imem_req, dmem_req, ir_we, pc_we, rf_we, retire, illegal, bus_err}),
            32'b0000_0010);
      tick();
    end
    apply_reset();
    check("rst_clears_illegal", 32'(illegal), 32'd0);

    // Undefined encoding is illegal too
    fetch_decode(rv32i_instr_e'(6'd50));
    #1;
    check("undef_trap", 32'({state, illegal}), 32'b111_1);
    apply_reset();

    // Fetch timeout: trap after exactly 16 FETCH cycles
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        check("to_last_fetch", 32'({state, imem_req, bus_err}), 32'b000_1_0);
      end
      tick();
    end
    check("to_trap", 32'({state, imem_req, bus_err, illegal}), 32'b111_0_1_0);
    apply_reset();

    // Reset asserted mid-MEM_REQ drops everything immediately
    fetch_decode(INSTR_LW);
    tick();
    check("mr_req", 32'({state, dmem_req}), 32'b011_1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_rst_outs", 32'(all_outs()), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mr_release", 32'({state, imem_req, dmem_req}), 32'b000_1_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
